// File: rtl/periph_ctrl_pkg.sv
// Shared definitions for the peripheral controller: slave indices,
// FSM state encoding and the system address map.
package configure;

   // Slave index, also the bit position in slave_valid / slave_ready
   typedef enum logic [1:0] {
      ROM   = 2'd0,
      PRINT = 2'd1,
      CLINT = 2'd2,
      BRAM  = 2'd3
   } slave_e;

   // FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t REQ  = 2'd1;
   localparam state_t BUSY = 2'd2;
   localparam state_t ERR  = 2'd3;

   // Address map, half-open ranges [base, top)
   localparam logic [31:0] rom_base_addr   = 32'h0000_0000;
   localparam logic [31:0] rom_top_addr    = 32'h0001_0000;
   localparam logic [31:0] print_base_addr = 32'h1000_0000;
   localparam logic [31:0] print_top_addr  = 32'h1000_1000;
   localparam logic [31:0] clint_base_addr = 32'h0200_0000;
   localparam logic [31:0] clint_top_addr  = 32'h0201_0000;
   localparam logic [31:0] bram_base_addr  = 32'h8000_0000;
   localparam logic [31:0] bram_top_addr   = 32'h8001_0000;

   // True when addr falls inside [base, top)
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] top);
      return (addr >= base) && (addr < top);
   endfunction

endpackage

// File: rtl/periph_ctrl_decode.sv
// Combinational address decoder: maps an absolute address to a slave
// index and that slave's base address.
module periph_decode
   import configure::*;
(
   input  logic [31:0] addr,
   output logic        hit,
   output slave_e      index,
   output logic [31:0] base
);

   // Later matches override earlier ones, giving bram > clint > print > rom
   always_comb begin
      hit   = 1'b0;
      index = ROM;
      base  = 32'h0;
      if (in_range(addr, rom_base_addr, rom_top_addr)) begin
         hit = 1'b1; index = ROM; base = rom_base_addr;
      end
      if (in_range(addr, print_base_addr, print_top_addr)) begin
         hit = 1'b1; index = PRINT; base = print_base_addr;
      end
      if (in_range(addr, clint_base_addr, clint_top_addr)) begin
         hit = 1'b1; index = CLINT; base = clint_base_addr;
      end
      if (in_range(addr, bram_base_addr, bram_top_addr)) begin
         hit = 1'b1; index = BRAM; base = bram_base_addr;
      end
   end

endmodule

// File: rtl/periph_ctrl.sv
// Single-outstanding bus bridge: decodes a master request, issues a
// one-cycle pulse to the selected slave and returns its response, or an
// error for unmapped addresses and slaves that never answer.
module periph_ctrl
   import configure::*;
#(
   parameter int TIMEOUT = 255,
   parameter int NSLV    = 4
) (
   input  logic                reset,
   input  logic                clock,
   input  logic                memory_valid,
   input  logic                memory_instr,
   input  logic [31:0]         memory_addr,
   input  logic [31:0]         memory_wdata,
   input  logic [3:0]          memory_wstrb,
   output logic [31:0]         memory_rdata,
   output logic                memory_ready,
   output logic                memory_error,
   output logic [NSLV-1:0]     slave_valid,
   output logic                slave_instr,
   output logic [31:0]         slave_addr,
   output logic [31:0]         slave_wdata,
   output logic [3:0]          slave_wstrb,
   input  logic [NSLV*32-1:0]  slave_rdata,
   input  logic [NSLV-1:0]     slave_ready
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t             state;
   slave_e             sel;
   logic [1:0]         sel_idx;
   logic [CNT_W-1:0]   cnt;

   logic               dec_hit;
   slave_e             dec_index;
   logic [31:0]        dec_base;

   logic               ready_sel;
   logic               done_ok;
   logic               done_to;

   periph_decode u_decode (
      .addr  (memory_addr),
      .hit   (dec_hit),
      .index (dec_index),
      .base  (dec_base)
   );

   assign sel_idx   = sel;
   assign ready_sel = slave_ready[sel_idx];
   // A ready in the timeout cycle still counts as success
   assign done_ok   = (state == BUSY) && ready_sel;
   assign done_to   = (state == BUSY) && !ready_sel && (cnt == CNT_W'(TIMEOUT));

   // Request capture, BUSY-cycle counter and state sequencing
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sel         <= ROM;
         cnt         <= '0;
         slave_instr <= 1'b0;
         slave_addr  <= 32'h0;
         slave_wdata <= 32'h0;
         slave_wstrb <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (memory_valid) begin
                  slave_instr <= memory_instr;
                  slave_addr  <= memory_addr - dec_base;
                  slave_wdata <= memory_wdata;
                  slave_wstrb <= memory_wstrb;
                  sel         <= dec_index;
                  state       <= dec_hit ? REQ : ERR;
               end
            end
            REQ: begin
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               if (done_ok || done_to) state <= IDLE;
               else                    cnt   <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Response and slave strobe generation, all zero outside their cycles
   always_comb begin
      slave_valid  = '0;
      if (state == REQ) slave_valid = NSLV'(1) << sel_idx;
      memory_ready = done_ok || done_to || (state == ERR);
      memory_error = done_to || (state == ERR);
      memory_rdata = done_ok ? slave_rdata[32*sel_idx +: 32] : 32'h0;
   end

endmodule

// File: tb/tb_periph_ctrl.sv
// Randomised self-checking bench for periph_ctrl with TIMEOUT=8.
module tb_periph_ctrl;

   localparam int TO = 8;
   localparam int NS = 4;

   logic          reset;
   logic          clock;
   logic          memory_valid;
   logic          memory_instr;
   logic [31:0]   memory_addr;
   logic [31:0]   memory_wdata;
   logic [3:0]    memory_wstrb;
   logic [31:0]   memory_rdata;
   logic          memory_ready;
   logic          memory_error;
   logic [NS-1:0] slave_valid;
   logic          slave_instr;
   logic [31:0]   slave_addr;
   logic [31:0]   slave_wdata;
   logic [3:0]    slave_wstrb;
   logic [NS*32-1:0] slave_rdata;
   logic [NS-1:0] slave_ready;

   int total = 0;
   int bad   = 0;

   // Independent copy of the address map: index 0 rom, 1 print, 2 clint, 3 bram
   logic [31:0] map_base [4] = '{32'h0000_0000, 32'h1000_0000, 32'h0200_0000, 32'h8000_0000};
   logic [31:0] map_top  [4] = '{32'h0001_0000, 32'h1000_1000, 32'h0201_0000, 32'h8001_0000};

   periph_ctrl #(.TIMEOUT(TO), .NSLV(NS)) dut (
      .reset        (reset),
      .clock        (clock),
      .memory_valid (memory_valid),
      .memory_instr (memory_instr),
      .memory_addr  (memory_addr),
      .memory_wdata (memory_wdata),
      .memory_wstrb (memory_wstrb),
      .memory_rdata (memory_rdata),
      .memory_ready (memory_ready),
      .memory_error (memory_error),
      .slave_valid  (slave_valid),
      .slave_instr  (slave_instr),
      .slave_addr   (slave_addr),
      .slave_wdata  (slave_wdata),
      .slave_wstrb  (slave_wstrb),
      .slave_rdata  (slave_rdata),
      .slave_ready  (slave_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference decode: highest-priority matching region wins
   function automatic bit ref_decode(input logic [31:0] a, output int idx, output logic [31:0] b);
      idx = 0;
      b   = 32'h0;
      for (int r = 3; r >= 0; r--) begin
         if (a >= map_base[r] && a < map_top[r]) begin
            idx = r;
            b   = map_base[r];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, "_rdy"},  {31'h0, memory_ready}, 32'h0);
      chk({tag, "_rdat"}, memory_rdata, 32'h0);
      chk({tag, "_sv"},   {28'h0, slave_valid}, 32'h0);
   endtask

   // One transaction: delay = BUSY cycle index at which the selected slave
   // answers (beyond TO means never), spur = noise on other ready lines
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                         input logic ins, input int delay, input logic [31:0] rd,
                         input bit spur, input int late);
      int          idx;
      logic [31:0] base;
      bit          hit;
      logic [NS-1:0] sr;
      hit = ref_decode(addr, idx, base);

      tick();
      memory_valid = 1'b1;
      memory_addr  = addr;
      memory_wdata = wd;
      memory_wstrb = ws;
      memory_instr = ins;
      slave_ready  = '0;
      #1;
      chk("accept_rdy", {31'h0, memory_ready}, 32'h0);

      tick();
      memory_valid = 1'($urandom_range(0, 1));
      memory_addr  = $urandom;
      memory_wdata = $urandom;
      memory_wstrb = 4'($urandom);
      memory_instr = 1'($urandom);
      slave_ready  = spur ? NS'($urandom) : '0;
      #1;
      if (!hit) begin
         chk("err_sv",   {28'h0, slave_valid}, 32'h0);
         chk("err_rdy",  {31'h0, memory_ready}, 32'h1);
         chk("err_err",  {31'h0, memory_error}, 32'h1);
         chk("err_rdat", memory_rdata, 32'h0);
      end else begin
         chk("req_sv",    {28'h0, slave_valid}, 32'h1 << idx);
         chk("req_addr",  slave_addr, addr - base);
         chk("req_wdata", slave_wdata, wd);
         chk("req_wstrb", {28'h0, slave_wstrb}, {28'h0, ws});
         chk("req_instr", {31'h0, slave_instr}, {31'h0, ins});
         chk("req_rdy",   {31'h0, memory_ready}, 32'h0);
         for (int k = 0; k <= TO; k++) begin
            tick();
            for (int s = 0; s < NS; s++) slave_rdata[32*s +: 32] = $urandom;
            slave_rdata[32*idx +: 32] = rd;
            sr      = spur ? NS'($urandom) : '0;
            sr[idx] = (k == delay);
            slave_ready  = sr;
            memory_valid = 1'($urandom_range(0, 1));
            memory_addr  = $urandom;
            #1;
            chk("busy_sv",   {28'h0, slave_valid}, 32'h0);
            chk("busy_addr", slave_addr, addr - base);
            chk("busy_wd",   slave_wdata, wd);
            if (k == delay) begin
               chk("ok_rdy",  {31'h0, memory_ready}, 32'h1);
               chk("ok_err",  {31'h0, memory_error}, 32'h0);
               chk("ok_rdat", memory_rdata, rd);
               break;
            end else if (k == TO) begin
               chk("to_rdy",  {31'h0, memory_ready}, 32'h1);
               chk("to_err",  {31'h0, memory_error}, 32'h1);
               chk("to_rdat", memory_rdata, 32'h0);
            end else begin
               chk("wait_rdy",  {31'h0, memory_ready}, 32'h0);
               chk("wait_rdat", memory_rdata, 32'h0);
            end
         end
      end
      // Afterwards the block idles; any ready, including a late one, is ignored
      for (int j = 0; j < late; j++) begin
         tick();
         memory_valid = 1'b0;
         slave_ready  = NS'($urandom) | (j == 1 ? NS'(1) << idx : '0);
         #1;
         check_quiet("post");
      end
      slave_ready  = '0;
      memory_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      reset        = 1'b0;
      memory_valid = 1'b0;
      memory_instr = 1'b0;
      memory_addr  = 32'h0;
      memory_wdata = 32'h0;
      memory_wstrb = 4'h0;
      slave_rdata  = '0;
      slave_ready  = '1;

      // Outputs during reset
      repeat (3) tick();
      check_quiet("rst");
      chk("rst_err",  {31'h0, memory_error}, 32'h0);
      chk("rst_addr", slave_addr, 32'h0);
      reset = 1'b1;
      slave_ready = '0;

      // Directed cases
      do_txn(32'h8000_0010, 32'h0, 4'h0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1);
      do_txn(32'h0200_0000, 32'h1, 4'hF, 1'b0, 2, 32'h0, 1'b0, 1);
      do_txn(32'hFFFF_FFF0, 32'h0, 4'h0, 1'b0, 0, 32'h0, 1'b0, 2);
      do_txn(32'h1000_0004, 32'h0, 4'h0, 1'b0, 100, 32'h0, 1'b0, 4);
      do_txn(32'h8000_0100, 32'h0, 4'h0, 1'b1, 5, 32'h1234_5678, 1'b1, 1);
      do_txn(32'h0000_0040, 32'h0, 4'h0, 1'b1, TO, 32'hCAFE_F00D, 1'b0, 1);
      // Range boundaries: last byte inside, first byte outside
      for (int b = 0; b < 4; b++) begin
         do_txn(map_top[b] - 32'h1, $urandom, 4'h3, 1'b0, 1, $urandom, 1'b1, 1);
         do_txn(map_top[b], $urandom, 4'h0, 1'b0, 1, $urandom, 1'b1, 1);
      end

      // Reset in BUSY drops the transaction
      tick();
      memory_valid = 1'b1;
      memory_addr  = 32'h8000_0004;
      memory_wdata = 32'hA5A5_A5A5;
      memory_wstrb = 4'hF;
      tick();
      memory_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_quiet("arst");
      chk("arst_addr",  slave_addr, 32'h0);
      chk("arst_wdata", slave_wdata, 32'h0);
      chk("arst_wstrb", {28'h0, slave_wstrb}, 32'h0);
      chk("arst_err",   {31'h0, memory_error}, 32'h0);
      tick();
      tick();
      reset = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         slave_ready = '1;
         #1;
         check_quiet("rel");
      end
      slave_ready = '0;
      do_txn(32'h0000_0100, 32'h0, 4'h0, 1'b1, 1, 32'h0BAD_C0DE, 1'b0, 1);

      // Random traffic
      for (int t = 0; t < 60; t++) begin
         r = $urandom_range(0, 4);
         if (r < 4) a = map_base[r] + ($urandom % (map_top[r] - map_base[r]));
         else       a = $urandom;
         do_txn(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, TO + 3),
                $urandom, 1'($urandom), $urandom_range(1, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
